// File: rtl/serial_rx_frame_ctrl.sv
// Oversampled serial frame receiver: start qualify, mid-bit sample,
// LSB-first shift, optional parity, stop check, valid/ready byte output.
module serial_rx_frame_ctrl #(
    parameter int OVERSAMPLE = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int HALF = OVERSAMPLE / 2;
    localparam int CW   = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] MID  = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_RESYNC
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          pbit;
    logic          data_smp, par_smp, stop_smp;
    logic          par_ok, good, ferr, perr, free;

    always_comb begin
        state_n  = state;
        cnt_n    = (cnt == LAST) ? '0 : cnt + 1'b1;
        data_smp = 1'b0;
        par_smp  = 1'b0;
        stop_smp = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!in) state_n = S_START;
            end
            S_START: begin
                if (cnt == MID) state_n = in ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (cnt == LAST) begin
                    data_smp = 1'b1;
                    if (idx == 3'd7) state_n = PARITY_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (cnt == LAST) begin
                    par_smp = 1'b1;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == LAST) begin
                    stop_smp = 1'b1;
                    state_n  = in ? S_IDLE : S_RESYNC;
                end
            end
            S_RESYNC: begin
                cnt_n = '0;
                if (in) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // every state change restarts the bit-phase counter
        if (state_n != state) cnt_n = '0;
    end

    always_comb begin
        par_ok = !PARITY_EN || (((^shreg) ^ pbit) == PARITY_ODD);
        ferr   = stop_smp && !in;
        perr   = stop_smp && in && !par_ok;
        good   = stop_smp && in && par_ok;
        free   = !out_valid || out_ready;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= 3'd0;
            shreg      <= 8'h00;
            pbit       <= 1'b0;
            out_byte   <= 8'h00;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            parity_err <= perr;
            frame_err  <= ferr;
            overrun    <= good && !free;
            if (data_smp) begin
                shreg <= {in, shreg[7:1]};
                idx   <= idx + 3'd1;
            end
            if (par_smp) pbit <= in;
            if (good && free) begin
                out_byte  <= shreg;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_rx_frame_ctrl.sv
// Scoreboard bench for serial_rx_frame_ctrl, parity on (even) and
// a second instance with parity disabled.
module tb_serial_rx_frame_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in = 1'b1, in2 = 1'b1;
    logic       out_ready = 1'b0, out_ready2 = 1'b1;
    logic [7:0] out_byte, out_byte2;
    logic       out_valid, out_valid2;
    logic       parity_err, frame_err, overrun, busy;
    logic       parity_err2, frame_err2, overrun2, busy2;

    int n_chk = 0;
    int n_fail = 0;
    logic [9:0] exp_q[$];

    logic       r_bsy0, r_ov1, r_ov, r_bz;
    logic [7:0] r_ob;
    logic [2:0] r_fl;

    always #5 clk = ~clk;

    serial_rx_frame_ctrl #(.OVERSAMPLE(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .reset(reset), .in(in),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    serial_rx_frame_ctrl #(.OVERSAMPLE(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut2 (
        .clk(clk), .reset(reset), .in(in2),
        .out_byte(out_byte2), .out_valid(out_valid2), .out_ready(out_ready2),
        .parity_err(parity_err2), .frame_err(frame_err2),
        .overrun(overrun2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // scoreboard entry: {kind, byte}; 0 byte, 1 parity, 2 frame, 3 overrun
    task automatic sb_pop(input string tag, input logic [9:0] obs);
        if (exp_q.size() == 0) chk({tag, "_unexp"}, {1'b1, obs}, 0);
        else chk(tag, obs, exp_q.pop_front());
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (parity_err || frame_err || overrun)
                chk("flag_in_reset", 1, 0);
        end else begin
            if (out_valid && out_ready) sb_pop("sb_byte", {2'd0, out_byte});
            if (parity_err || frame_err || overrun)
                chk("flag_onehot", $countones({parity_err, frame_err, overrun}), 1);
            if (parity_err) sb_pop("sb_parity", {2'd1, 8'h00});
            if (frame_err)  sb_pop("sb_frame",  {2'd2, 8'h00});
            if (overrun)    sb_pop("sb_overrun", {2'd3, 8'h00});
        end
    end

    // edge index e of the loop is posedge t0+e; values recorded #1 after it
    task automatic send(input bit two, input logic [7:0] d, input logic p,
                        input logic stp, input int rdy_at);
        logic [10:0] bits;
        int nb, ts;
        bits = two ? {1'b0, stp, d, 1'b0} : {stp, p, d, 1'b0};
        nb   = two ? 10 : 11;
        ts   = two ? 38 : 42;
        for (int e = 0; e < nb * 4; e++) begin
            if (two) in2 = bits[e / 4];
            else in = bits[e / 4];
            @(posedge clk); #1;
            if (e == 0) r_bsy0 = two ? busy2 : busy;
            if (e == ts - 1) r_ov1 = two ? out_valid2 : out_valid;
            if (e == rdy_at) out_ready = 1'b1;
            if (e == ts) begin
                r_ov = two ? out_valid2 : out_valid;
                r_ob = two ? out_byte2 : out_byte;
                r_bz = two ? busy2 : busy;
                r_fl = {parity_err, frame_err, overrun};
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        idle(3);
        chk("rst_byte", out_byte, 8'h00);
        chk("rst_valid", out_valid, 0);
        chk("rst_flags", {parity_err, frame_err, overrun}, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        idle(3);

        // good frame
        out_ready = 1'b1;
        exp_q.push_back({2'd0, 8'hA5});
        send(0, 8'hA5, ^8'hA5, 1'b1, -1);
        chk("a5_busy_t0", r_bsy0, 1);
        chk("a5_valid_pre", r_ov1, 0);
        chk("a5_valid", r_ov, 1);
        chk("a5_byte", r_ob, 8'hA5);
        chk("a5_flags", r_fl, 0);
        chk("a5_busy_ts", r_bz, 0);
        chk("a5_valid_drop", out_valid, 0);
        idle(4);

        // start glitch
        in = 1'b0;
        @(posedge clk); #1;
        in = 1'b1;
        chk("glitch_busy", busy, 1);
        idle(2);
        chk("glitch_idle", busy, 0);
        idle(8);

        // parity error
        exp_q.push_back({2'd1, 8'h00});
        send(0, 8'h01, ~(^8'h01), 1'b1, -1);
        chk("par_flags", r_fl, 3'b100);
        chk("par_valid", r_ov, 0);
        idle(4);

        // framing error, then resync and a good frame
        exp_q.push_back({2'd2, 8'h00});
        send(0, 8'h3C, ^8'h3C, 1'b0, -1);
        chk("frm_flags", r_fl, 3'b010);
        chk("frm_valid", r_ov, 0);
        idle(6);
        chk("frm_resync", busy, 1);
        in = 1'b1;
        idle(2);
        chk("frm_idle", busy, 0);
        exp_q.push_back({2'd0, 8'h7E});
        send(0, 8'h7E, ^8'h7E, 1'b1, -1);
        chk("7e_valid", r_ov, 1);
        chk("7e_byte", r_ob, 8'h7E);
        idle(4);

        // overrun
        out_ready = 1'b0;
        exp_q.push_back({2'd3, 8'h00});
        exp_q.push_back({2'd0, 8'h11});
        send(0, 8'h11, ^8'h11, 1'b1, -1);
        chk("11_byte", r_ob, 8'h11);
        idle(5);
        chk("11_held", out_valid, 1);
        send(0, 8'h22, ^8'h22, 1'b1, -1);
        chk("ovr_flags", r_fl, 3'b001);
        chk("ovr_keep", r_ob, 8'h11);
        chk("ovr_valid", r_ov, 1);
        out_ready = 1'b1;
        idle(1);
        chk("ovr_drain", out_valid, 0);
        idle(4);

        // back-to-back replace with no gap
        out_ready = 1'b0;
        exp_q.push_back({2'd0, 8'h55});
        exp_q.push_back({2'd0, 8'hAA});
        send(0, 8'h55, ^8'h55, 1'b1, -1);
        send(0, 8'hAA, ^8'hAA, 1'b1, 41);
        chk("b2b_pre", r_ov1, 1);
        chk("b2b_valid", r_ov, 1);
        chk("b2b_byte", r_ob, 8'hAA);
        chk("b2b_flags", r_fl, 0);
        idle(4);

        // reset mid-frame
        for (int e = 0; e < 20; e++) begin
            in = e < 4 ? 1'b0 : e[2];
            @(posedge clk); #1;
        end
        reset = 1'b1;
        idle(1);
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_byte", out_byte, 8'h00);
        chk("mrst_flags", {parity_err, frame_err, overrun}, 0);
        in = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(60);
        chk("mrst_quiet", busy, 0);

        // parity disabled instance
        send(1, 8'hA5, 1'b0, 1'b1, -1);
        chk("np_valid_pre", r_ov1, 0);
        chk("np_valid", r_ov, 1);
        chk("np_byte", r_ob, 8'hA5);
        chk("np_busy_ts", r_bz, 0);
        chk("np_flags", {parity_err2, frame_err2, overrun2}, 0);
        idle(4);

        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
